// File: rtl/rr_mux_stage.sv
// rr_mux_stage: N-channel round-robin / fixed-priority selector feeding one
// registered valid/ready output stage.
module rr_mux_stage #(
  parameter int WIDTH = 32,
  parameter int N = 4,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);
  logic [SEL_W-1:0] ptr, g, idx;
  logic found, accept, xfer;
  int j;
  // Scan starts at ptr in round-robin mode, at 0 in fixed-priority mode.
  always_comb begin
    found = 1'b0;
    g = '0;
    j = 0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      j = (mode ? 0 : int'(ptr)) + k;
      if (j >= N) j = j - N;
      idx = SEL_W'(j);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
  end
  assign accept = !out_valid || out_ready;
  assign xfer = found && accept;
  assign in_ready = xfer ? (N'(1) << g) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      ptr <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= in_data[g*WIDTH +: WIDTH];
      out_sel <= g;
      ptr <= (g == SEL_W'(N-1)) ? '0 : g + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_mux_stage.sv
// tb_rr_mux_stage: directed and random checks of a 4-channel and a 3-channel
// rr_mux_stage against a queue-free behavioural model.
module tb_rr_mux_stage;
  logic clk = 1'b0;
  logic reset, mode;
  logic [127:0] in_data4;
  logic [3:0] in_valid4, in_ready4;
  logic [31:0] out_data4;
  logic [1:0] out_sel4;
  logic out_valid4, out_ready4;
  logic [23:0] in_data3;
  logic [2:0] in_valid3, in_ready3;
  logic [7:0] out_data3;
  logic [1:0] out_sel3;
  logic out_valid3, out_ready3;
  int n_checks = 0;
  int n_fail = 0;
  int m_ptr[2];
  logic m_v[2];
  logic [31:0] m_d[2];
  int m_s[2];

  always #5 clk = ~clk;

  rr_mux_stage #(.WIDTH(32), .N(4)) dut4 (
    .clk(clk), .reset(reset), .mode(mode),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_data(out_data4), .out_sel(out_sel4), .out_valid(out_valid4),
    .out_ready(out_ready4)
  );
  rr_mux_stage #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .reset(reset), .mode(mode),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  function automatic int nch(input int d);
    return d ? 3 : 4;
  endfunction
  function automatic logic [3:0] cur_valid(input int d);
    return d ? {1'b0, in_valid3} : in_valid4;
  endfunction
  function automatic logic cur_ordy(input int d);
    return d ? out_ready3 : out_ready4;
  endfunction
  function automatic logic [31:0] cur_data(input int d, input int c);
    return d ? 32'(in_data3[c*8 +: 8]) : in_data4[c*32 +: 32];
  endfunction
  // Channel the arbiter should pick, or -1 when nothing is valid.
  function automatic int grant(input int d);
    int start = mode ? 0 : m_ptr[d];
    logic [3:0] v = cur_valid(d);
    for (int k = 0; k < nch(d); k++)
      if (v[(start + k) % nch(d)]) return (start + k) % nch(d);
    return -1;
  endfunction
  function automatic logic [3:0] exp_ready(input int d);
    int c = grant(d);
    return (c >= 0 && (!m_v[d] || cur_ordy(d))) ? 4'(1) << c : 4'b0;
  endfunction

  task automatic tick();
    int c;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_v[d] = 1'b0; m_d[d] = '0; m_s[d] = 0; m_ptr[d] = 0;
      end else begin
        c = grant(d);
        if (c >= 0 && (!m_v[d] || cur_ordy(d))) begin
          m_v[d] = 1'b1; m_d[d] = cur_data(d, c); m_s[d] = c;
          m_ptr[d] = (c + 1) % nch(d);
        end else if (cur_ordy(d)) m_v[d] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 1'b0;
    in_valid4 = 4'b1111; out_ready4 = 1'b1;
    in_valid3 = 3'b000; out_ready3 = 1'b1;
    for (int i = 0; i < 4; i++) in_data4[i*32 +: 32] = 32'hA0 + i;
    for (int i = 0; i < 3; i++) in_data3[i*8 +: 8] = 8'h30 + 8'(i);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if ({out_valid4, out_data4, out_sel4} !== 35'b0) begin
        n_fail++;
        $display("FAIL reset_out cyc %0d: valid=%b data=%h sel=%0d, required 0/0/0", c, out_valid4, out_data4, out_sel4);
      end
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready4 !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b required 0001", in_ready4);
    end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (out_valid4 !== 1'b1 || out_sel4 !== 2'(k % 4) || out_data4 !== 32'hA0 + 32'(k % 4)) begin
        n_fail++;
        $display("FAIL rr_seq step %0d: valid=%b sel=%0d data=%h, required 1/%0d/%h", k, out_valid4, out_sel4, out_data4, k % 4, 32'hA0 + k % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    in_valid4 = 4'b0010;
    tick();
    n_checks++;
    if (out_data4 !== 32'hA1 || out_sel4 !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_load: data=%h sel=%0d, required a1/1", out_data4, out_sel4);
    end
    out_ready4 = 1'b0; in_valid4 = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (in_ready4 !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_ready cyc %0d: in_ready=%b required 0000", c, in_ready4);
      end
      tick();
      n_checks++;
      if (out_valid4 !== 1'b1 || out_data4 !== 32'hA1 || out_sel4 !== 2'd1) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d: valid=%b data=%h sel=%0d, required 1/a1/1", c, out_valid4, out_data4, out_sel4);
      end
    end
    out_ready4 = 1'b1;
    #1;
    n_checks++;
    if (in_ready4 !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_release_ready: in_ready=%b required 0100", in_ready4);
    end
    tick();
    n_checks++;
    if (out_sel4 !== 2'd2 || out_data4 !== 32'hA2) begin
      n_fail++;
      $display("FAIL bp_release: sel=%0d data=%h, required 2/a2", out_sel4, out_data4);
    end
  endtask

  task automatic test_fixed_priority();
    mode = 1'b1; in_valid4 = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (out_sel4 !== 2'd1 || out_valid4 !== 1'b1) begin
        n_fail++;
        $display("FAIL fixed_prio cyc %0d: sel=%0d valid=%b, required 1/1", c, out_sel4, out_valid4);
      end
    end
    mode = 1'b0;
    #1;
    n_checks++;
    if (in_ready4 !== 4'b1000) begin
      n_fail++;
      $display("FAIL mode_switch_ready: in_ready=%b required 1000", in_ready4);
    end
    tick();
    n_checks++;
    if (out_sel4 !== 2'd3) begin
      n_fail++;
      $display("FAIL mode_switch: sel=%0d required 3", out_sel4);
    end
  endtask

  task automatic test_wrap3();
    in_valid4 = 4'b0000; in_valid3 = 3'b111; mode = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (out_valid3 !== 1'b1 || out_sel3 !== 2'(k % 3) || out_data3 !== 8'h30 + 8'(k % 3)) begin
        n_fail++;
        $display("FAIL wrap3 step %0d: valid=%b sel=%0d data=%h, required 1/%0d/%h", k, out_valid3, out_sel3, out_data3, k % 3, 8'h30 + 8'(k % 3));
      end
    end
    in_valid3 = 3'b000;
  endtask

  task automatic test_reset_mid();
    in_valid4 = 4'b0100; out_ready4 = 1'b0;
    tick();
    tick();
    n_checks++;
    if (out_valid4 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_load: valid=%b required 1", out_valid4);
    end
    reset = 1'b1; in_valid4 = 4'b0000;
    tick();
    reset = 1'b0; out_ready4 = 1'b1; in_valid4 = 4'b1111;
    n_checks++;
    if (out_valid4 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_valid: valid=%b required 0", out_valid4);
    end
    #1;
    n_checks++;
    if (in_ready4 !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_reset_ptr: in_ready=%b required 0001", in_ready4);
    end
    tick();
    n_checks++;
    if (out_sel4 !== 2'd0 || out_data4 !== 32'hA0) begin
      n_fail++;
      $display("FAIL mid_reset_next: sel=%0d data=%h required 0/a0", out_sel4, out_data4);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 39) == 0);
      mode = ($urandom_range(0, 3) == 0);
      in_valid4 = 4'($urandom); in_valid3 = 3'($urandom);
      out_ready4 = ($urandom_range(0, 2) != 0); out_ready3 = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < 4; i++) in_data4[i*32 +: 32] = $urandom;
      in_data3 = 24'($urandom);
      #1;
      n_checks++;
      if (in_ready4 !== exp_ready(0) || {1'b0, in_ready3} !== exp_ready(1)) begin
        n_fail++;
        $display("FAIL rand_ready cyc %0d: r4=%b r3=%b, required %b %b", c, in_ready4, in_ready3, exp_ready(0), exp_ready(1)[2:0]);
      end
      tick();
      n_checks++;
      if (out_valid4 !== m_v[0] || out_data4 !== m_d[0] || out_sel4 !== 2'(m_s[0])) begin
        n_fail++;
        $display("FAIL rand_out4 cyc %0d: v=%b d=%h s=%0d, required %b %h %0d", c, out_valid4, out_data4, out_sel4, m_v[0], m_d[0], m_s[0]);
      end
      n_checks++;
      if (out_valid3 !== m_v[1] || out_data3 !== m_d[1][7:0] || out_sel3 !== 2'(m_s[1])) begin
        n_fail++;
        $display("FAIL rand_out3 cyc %0d: v=%b d=%h s=%0d, required %b %h %0d", c, out_valid3, out_data3, out_sel3, m_v[1], m_d[1][7:0], m_s[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_fixed_priority();
    test_wrap3();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
